four_bit_sync_down_cntr: RTL and testbench

FOUR_BIT_SYNC_DOWN_CNTR -- requirements
Module: four_bit_sync_down_cntr

---
 rtl/four_bit_sync_down_cntr.sv | 63 ++++++
 tb/tb_four_bit_sync_down_cntr.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/four_bit_sync_down_cntr.sv
// Loadable 4-bit down counter with IDLE/RUN/DONE control; DOWN_CNTR_AUTO_RELOAD_EN picks reload-on-borrow vs stop-in-DONE.
// Latency: count/state update one clk edge after load/cnt_en; borrow is combinational; no backpressure.
module four_bit_sync_down_cntr (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       cnt_en,
    output logic [3:0] count,
    output logic       borrow,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [3:0] reload_q, reload_d;

    // Gated by rst so an aborted sequence never cascades a stray strobe downstream.
    assign borrow = !rst && (state_q == ST_RUN) && cnt_en && !load && (count_q == 4'd0);
    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign count  = count_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        if (load) begin
            state_d  = ST_RUN;
            count_d  = load_val;
            reload_d = load_val;
        end else if ((state_q == ST_RUN) && cnt_en) begin
            if (count_q == 4'd0) begin
`ifdef DOWN_CNTR_AUTO_RELOAD_EN
                count_d = reload_q;
`else
                state_d = ST_DONE;
                count_d = 4'd0;
`endif
            end else begin
                count_d = count_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= 4'd0;
            reload_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end

endmodule

// File: tb/tb_four_bit_sync_down_cntr.sv
// Directed vectors with a scoreboard queue for four_bit_sync_down_cntr, plus a two-stage cascade check.
module tb_four_bit_sync_down_cntr;

`ifdef DOWN_CNTR_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic       load;
        logic [3:0] lv;
        logic       en;
        logic       chk;
        logic [6:0] exp;   // {count, borrow, busy, done}
    } vec_t;

    typedef struct packed {
        int         idx;
        logic [6:0] exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst, load, cnt_en;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       borrow, busy, done;

    logic       c_rst, c_load, c_en;
    logic [3:0] c_lv;
    logic [3:0] lo_count, hi_count;
    logic       lo_borrow, lo_busy, lo_done;
    logic       hi_borrow, hi_busy, hi_done;

    int total = 0;
    int bad   = 0;

    vec_t vecs[$];
    sb_t  sb_q[$];

    always #5 clk = ~clk;

    four_bit_sync_down_cntr dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .cnt_en(cnt_en),
        .count(count), .borrow(borrow), .busy(busy), .done(done)
    );

    four_bit_sync_down_cntr u_lo (
        .clk(clk), .rst(c_rst), .load(c_load), .load_val(c_lv), .cnt_en(c_en),
        .count(lo_count), .borrow(lo_borrow), .busy(lo_busy), .done(lo_done)
    );

    four_bit_sync_down_cntr u_hi (
        .clk(clk), .rst(c_rst), .load(c_load), .load_val(c_lv), .cnt_en(lo_borrow),
        .count(hi_count), .borrow(hi_borrow), .busy(hi_busy), .done(hi_done)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic l, input logic [3:0] v, input logic e,
                       input logic c, input logic [3:0] ec, input logic eb,
                       input logic ebz, input logic edn);
        vec_t t;
        t.rst = r; t.load = l; t.lv = v; t.en = e; t.chk = c;
        t.exp = {ec, eb, ebz, edn};
        vecs.push_back(t);
    endtask

    // Monitor: every cycle the DUT presents a value; compare against the oldest expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            check($sformatf("vec%0d", e.idx), int'({count, borrow, busy, done}), int'(e.exp));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_k;
        //   rst load lv  en chk  count           borrow busy  done
        add(1, 0, 0, 0, 0, 0,               0,  0,   0);
        add(1, 0, 0, 1, 1, 0,               0,  0,   0);
        add(0, 0, 0, 1, 1, 0,               0,  0,   0);
        add(0, 0, 0, 1, 1, 0,               0,  0,   0);
        add(0, 1, 3, 1, 1, 0,               0,  0,   0);
        add(0, 0, 0, 1, 1, 3,               0,  1,   0);
        add(0, 0, 0, 1, 1, 2,               0,  1,   0);
        add(0, 0, 0, 1, 1, 1,               0,  1,   0);
        add(0, 0, 0, 1, 1, 0,               1,  1,   0);
        add(0, 0, 0, 1, 1, AR ? 4'd3 : 4'd0, 0,  AR,  !AR);
        add(0, 0, 0, 1, 1, AR ? 4'd2 : 4'd0, 0,  AR,  !AR);
        add(0, 0, 0, 1, 1, AR ? 4'd1 : 4'd0, 0,  AR,  !AR);
        add(0, 0, 0, 1, 1, 0,               AR, AR,  !AR);
        add(0, 0, 0, 1, 1, AR ? 4'd3 : 4'd0, 0,  AR,  !AR);
        add(0, 1, 5, 1, 1, AR ? 4'd2 : 4'd0, 0,  AR,  !AR);
        add(0, 0, 0, 1, 1, 5,               0,  1,   0);
        add(0, 0, 0, 0, 1, 4,               0,  1,   0);
        add(0, 0, 0, 1, 1, 4,               0,  1,   0);
        add(0, 0, 0, 0, 1, 3,               0,  1,   0);
        add(0, 0, 0, 1, 1, 3,               0,  1,   0);
        add(0, 1, 9, 1, 1, 2,               0,  1,   0);
        add(0, 0, 0, 1, 1, 9,               0,  1,   0);
        add(0, 0, 0, 1, 1, 8,               0,  1,   0);
        add(0, 1, 0, 1, 1, 7,               0,  1,   0);
        add(0, 0, 0, 1, 1, 0,               1,  1,   0);
        add(0, 0, 0, 0, 1, 0,               0,  AR,  !AR);
        add(0, 0, 0, 1, 1, 0,               AR, AR,  !AR);
        add(0, 1, 2, 0, 1, 0,               0,  AR,  !AR);
        add(0, 0, 0, 0, 1, 2,               0,  1,   0);
        add(0, 0, 0, 1, 1, 2,               0,  1,   0);
        add(1, 0, 0, 1, 1, 1,               0,  1,   0);
        add(0, 0, 0, 1, 1, 0,               0,  0,   0);
        add(0, 1, 0, 0, 1, 0,               0,  0,   0);
        add(1, 0, 0, 1, 1, 0,               0,  1,   0);
        add(0, 0, 0, 1, 1, 0,               0,  0,   0);

        rst = 1'b1; load = 1'b0; load_val = 4'd0; cnt_en = 1'b0;
        c_rst = 1'b1; c_load = 1'b0; c_lv = 4'd15; c_en = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst      = vecs[i].rst;
            load     = vecs[i].load;
            load_val = vecs[i].lv;
            cnt_en   = vecs[i].en;
            if (vecs[i].chk) begin
                sb_t s;
                s.idx = i;
                s.exp = vecs[i].exp;
                sb_q.push_back(s);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0; load = 1'b0; cnt_en = 1'b0;

        // Cascade: low stage borrow feeds the high stage enable.
        @(posedge clk); #1; c_rst = 1'b1;
        @(posedge clk); #1; c_rst = 1'b0; c_load = 1'b1;
        @(posedge clk); #1; c_load = 1'b0; c_en = 1'b1;
        first_k = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (hi_borrow === 1'b1) begin
                first_k = k;
                break;
            end
        end
        check("cascade_borrow_cycle", first_k, AR ? 256 : 0);
        check("cascade_hi_count", int'(hi_count), AR ? 0 : 14);
        check("cascade_lo_done", int'(lo_done), AR ? 0 : 1);

        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
        if (sb_q.size() > 0) check("scoreboard_drain", sb_q.size(), 0);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
